// File: rtl/uart_result_tx_if.sv
// Handshake and serial-line bundle between the result register, the
// transmitter and the board tx pin.
interface uart_result_tx_if;
  logic       start;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output start, output data, input tx, input busy, input done);
  modport slave  (input start, input data, output tx, output busy, output done);
endinterface

// File: rtl/uart_result_tx.sv
// Sends one result byte as four 8N1 characters: two uppercase hex digits,
// then CR and LF, back to back on the tx line.
module uart_result_tx #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  uart_result_tx_if.slave  bus
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [7:0]       shadow_q,   shadow_d;
  logic [1:0]       char_idx_q, char_idx_d;
  logic [2:0]       bit_idx_q,  bit_idx_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             tx_q,       tx_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic [7:0]       cur_char;
  logic             bit_end;
  logic [2:0]       next_bit;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

  // Character currently on the line, selected from the captured byte
  always_comb begin
    cur_char = 8'h0A;
    unique case (char_idx_q)
      2'd0:    cur_char = hex_ascii(shadow_q[7:4]);
      2'd1:    cur_char = hex_ascii(shadow_q[3:0]);
      2'd2:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  assign bit_end  = (cnt_q == CNT_LAST);
  assign next_bit = bit_idx_q + 3'd1;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      char_idx_q <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      char_idx_q <= char_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // tx_d is derived from the state being entered so the line is registered
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          shadow_d   = bus.data;
          char_idx_d = 2'd0;
          cnt_d      = '0;
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = cur_char[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = next_bit;
            tx_d      = cur_char[next_bit];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (char_idx_q != 2'd3) begin
            char_idx_d = char_idx_q + 2'd1;
            state_d    = S_START;
            tx_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx at 10 clocks per bit: checks every
// bit-time of every character cycle by cycle, plus reset and handshake edges.
module tb_uart_result_tx;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  uart_result_tx_if u_if ();

  uart_result_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [7:0] d);
    u_if.start = 1'b1;
    u_if.data  = d;
  endtask

  // Called at the negedge of the accepting cycle; returns at the done cycle.
  task automatic frame(input string name, input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic [7:0] c3, input bit noisy);
    logic [7:0] chars [4];
    logic [9:0] frm;
    logic [9:0] txv;
    int         k;
    int         busy_n;
    int         done_n;
    chars = '{c0, c1, c2, c3};
    k = 0;
    for (int c = 0; c < 4; c++) begin
      frm    = {1'b1, chars[c], 1'b0};
      busy_n = 0;
      done_n = 0;
      for (int b = 0; b < 10; b++) begin
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          k++;
          txv[s] = u_if.tx;
          busy_n += int'(u_if.busy);
          done_n += int'(u_if.done);
          if (k == 1) u_if.start = 1'b0;
          if (noisy) begin
            u_if.data  = 8'($urandom);
            u_if.start = (k == 150);
          end
        end
        chk($sformatf("%s_c%0d_b%0d_tx", name, c, b), 32'(txv), frm[b] ? 32'h3ff : 32'h0);
      end
      chk($sformatf("%s_c%0d_busy", name, c), 32'(busy_n), 32'd100);
      chk($sformatf("%s_c%0d_nodone", name, c), 32'(done_n), 32'd0);
    end
    @(negedge clk);
    chk({name, "_done"}, 32'(u_if.done), 32'd1);
    chk({name, "_done_busy"}, 32'(u_if.busy), 32'd0);
    chk({name, "_done_tx"}, 32'(u_if.tx), 32'd1);
  endtask

  task automatic idle_chk(input string name);
    @(negedge clk);
    chk({name, "_idle"}, {29'd0, u_if.tx, u_if.busy, u_if.done}, 32'b100);
  endtask

  initial begin
    int tx_low;
    int busy_n;
    int done_n;
    u_if.start = 1'b0;
    u_if.data  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, u_if.tx, u_if.busy, u_if.done}, 32'b100);
    reset = 1'b0;
    idle_chk("post_rst");

    // reset and start together: reset wins
    reset = 1'b1;
    launch(8'hA5);
    @(negedge clk);
    chk("rst_start_busy", 32'(u_if.busy), 32'd0);
    chk("rst_start_tx", 32'(u_if.tx), 32'd1);
    reset = 1'b0;
    u_if.start = 1'b0;
    idle_chk("rst_start_after");

    launch(8'h3C); frame("x3C", 8'h33, 8'h43, 8'h0D, 8'h0A, 1'b0); idle_chk("x3C");
    launch(8'h09); frame("x09", 8'h30, 8'h39, 8'h0D, 8'h0A, 1'b0); idle_chk("x09");
    launch(8'hAF); frame("xAF", 8'h41, 8'h46, 8'h0D, 8'h0A, 1'b0); idle_chk("xAF");
    launch(8'hFF); frame("xFF", 8'h46, 8'h46, 8'h0D, 8'h0A, 1'b0); idle_chk("xFF");
    launch(8'h00); frame("x00", 8'h30, 8'h30, 8'h0D, 8'h0A, 1'b0); idle_chk("x00");

    // ignored start with noisy data, then back-to-back launch in the done cycle
    launch(8'h12); frame("x12", 8'h31, 8'h32, 8'h0D, 8'h0A, 1'b1);
    launch(8'h5A); frame("x5A", 8'h35, 8'h41, 8'h0D, 8'h0A, 1'b0); idle_chk("x5A");

    // reset inside character 1 data bits
    launch(8'h34);
    for (int k = 1; k <= 125; k++) begin
      @(negedge clk);
      if (k == 1) u_if.start = 1'b0;
    end
    chk("mid_tx_before_rst", 32'(u_if.tx), 32'd0);
    chk("mid_busy_before_rst", 32'(u_if.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", 32'(u_if.tx), 32'd1);
    chk("mid_rst_busy", 32'(u_if.busy), 32'd0);
    chk("mid_rst_done", 32'(u_if.done), 32'd0);
    reset = 1'b0;
    tx_low = 0; busy_n = 0; done_n = 0;
    repeat (500) begin
      @(negedge clk);
      tx_low += int'(!u_if.tx);
      busy_n += int'(u_if.busy);
      done_n += int'(u_if.done);
    end
    chk("post_rst_tx_low", 32'(tx_low), 32'd0);
    chk("post_rst_busy", 32'(busy_n), 32'd0);
    chk("post_rst_done", 32'(done_n), 32'd0);
    launch(8'h7E); frame("x7E", 8'h37, 8'h45, 8'h0D, 8'h0A, 1'b0); idle_chk("x7E");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
